// File: rtl/led_bank_arbiter.sv
// Round-robin owner of the 8-LED bank: bounded tenures under contention,
// live tracking of the owner's pattern, heartbeat on the MSB when idle.
module led_bank_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int HOLD_CYCLES     = 15_000_000,
  parameter int HEARTBEAT_WIDTH = 25
) (
  input  logic                 sysclk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] pattern,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 busy,
  output logic [7:0]           leds
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic [0:0] {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t                 state_r, state_s;
  logic [NUM_REQ-1:0]     grant_r, grant_s;
  logic [PW-1:0]          own_r, own_s;
  logic [PW-1:0]          ptr_r, ptr_s;
  logic [TW-1:0]          tcnt_r, tcnt_s;
  logic [7:0]             leds_r, leds_s;
  logic                   busy_r;
  logic [HEARTBEAT_WIDTH-1:0] hb_r;
  logic [PW:0]            pick_s;
  logic [PW-1:0]          win_s;
  logic [7:0]             hb_leds_s;

  // First requester at or after p, wrapping; MSB of the result flags a hit.
  function automatic logic [PW:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                          input logic [PW-1:0] p);
    logic [PW:0] res;
    int          idx;
    res = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = (int'(p) + i) % NUM_REQ;
      res = r[idx] ? {1'b1, PW'(idx)} : res;
    end
    return res;
  endfunction

  function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] w);
    return (w == PW'(NUM_REQ - 1)) ? '0 : w + PW'(1);
  endfunction

  assign pick_s    = rr_pick(req, ptr_r);
  assign win_s     = pick_s[PW-1:0];
  assign hb_leds_s = {hb_r[HEARTBEAT_WIDTH-1], 7'b0};

  // Next-state and next-output decode for the ownership FSM.
  always_comb begin
    state_s = state_r;
    grant_s = grant_r;
    own_s   = own_r;
    ptr_s   = ptr_r;
    tcnt_s  = tcnt_r;
    leds_s  = hb_leds_s;
    case (state_r)
      IDLE: begin
        if (pick_s[PW]) begin
          state_s = HOLD;
          grant_s = NUM_REQ'(1) << win_s;
          own_s   = win_s;
          ptr_s   = next_idx(win_s);
          tcnt_s  = TW'(HOLD_CYCLES - 1);
          leds_s  = pattern[8*int'(win_s) +: 8];
        end else begin
          grant_s = '0;
          leds_s  = hb_leds_s;
        end
      end
      HOLD: begin
        if (!req[own_r]) begin
          state_s = IDLE;
          grant_s = '0;
          leds_s  = hb_leds_s;
        end else if (tcnt_r == TW'(0)) begin
          // Owner is still requesting, so the search always hits; it is scanned last.
          grant_s = NUM_REQ'(1) << win_s;
          own_s   = win_s;
          ptr_s   = next_idx(win_s);
          tcnt_s  = TW'(HOLD_CYCLES - 1);
          leds_s  = pattern[8*int'(win_s) +: 8];
        end else begin
          tcnt_s  = tcnt_r - TW'(1);
          leds_s  = pattern[8*int'(own_r) +: 8];
        end
      end
      default: begin
        state_s = IDLE;
        grant_s = '0;
        leds_s  = hb_leds_s;
      end
    endcase
  end

  // State, output and heartbeat registers.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_r <= IDLE;
      grant_r <= '0;
      own_r   <= '0;
      ptr_r   <= '0;
      tcnt_r  <= '0;
      leds_r  <= 8'h00;
      busy_r  <= 1'b0;
      hb_r    <= '0;
    end else begin
      state_r <= state_s;
      grant_r <= grant_s;
      own_r   <= own_s;
      ptr_r   <= ptr_s;
      tcnt_r  <= tcnt_s;
      leds_r  <= leds_s;
      busy_r  <= |grant_s;
      hb_r    <= hb_r + HEARTBEAT_WIDTH'(1);
    end
  end

  assign grant = grant_r;
  assign busy  = busy_r;
  assign leds  = leds_r;

endmodule

// File: tb/tb_led_bank_arbiter.sv
// Directed plus randomized bench for led_bank_arbiter, checked cycle by cycle
// against an owner/tenure reference model.
module tb_led_bank_arbiter;

  localparam int N  = 4;
  localparam int HC = 4;
  localparam int HW = 4;

  logic           sysclk = 1'b0;
  logic           reset  = 1'b1;
  logic [N-1:0]   req    = '0;
  logic [8*N-1:0] pattern = '0;
  logic [N-1:0]   grant;
  logic           busy;
  logic [7:0]     leds;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: owner (-1 = none), rotation start, cycles left, heartbeat.
  int   m_owner = -1;
  int   m_ptr   = 0;
  int   m_left  = 0;
  int   m_hb    = 0;
  logic [7:0] m_leds = 8'h00;

  led_bank_arbiter #(.NUM_REQ(N), .HOLD_CYCLES(HC), .HEARTBEAT_WIDTH(HW)) dut (
    .sysclk  (sysclk),
    .reset   (reset),
    .req     (req),
    .pattern (pattern),
    .grant   (grant),
    .busy    (busy),
    .leds    (leds)
  );

  always #5 sysclk = ~sysclk;

  function automatic int search(input logic [N-1:0] r, input int p);
    for (int i = 0; i < N; i++)
      if (r[(p + i) % N]) return (p + i) % N;
    return -1;
  endfunction

  function automatic logic [7:0] pat_of(input int i);
    return 8'((pattern >> (8 * i)) & 32'hFF);
  endfunction

  task automatic model_step();
    int w;
    logic [7:0] hbl;
    hbl = ((m_hb >> (HW - 1)) & 1) != 0 ? 8'h80 : 8'h00;
    if (reset) begin
      m_owner = -1; m_ptr = 0; m_left = 0; m_hb = 0; m_leds = 8'h00;
      return;
    end
    if (m_owner >= 0 && !req[m_owner]) begin
      m_owner = -1;
      m_leds  = hbl;
    end else if (m_owner < 0 || m_left == 0) begin
      w = search(req, m_ptr);
      if (w >= 0) begin
        m_owner = w; m_ptr = (w + 1) % N; m_left = HC - 1; m_leds = pat_of(w);
      end else begin
        m_leds = hbl;
      end
    end else begin
      m_left--;
      m_leds = pat_of(m_owner);
    end
    m_hb = (m_hb + 1) % (1 << HW);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, update the model, then compare #1 after the edge.
  task automatic tick();
    logic [N-1:0] eg;
    @(posedge sysclk);
    model_step();
    #1;
    eg = (m_owner < 0) ? '0 : N'(1) << m_owner;
    chk("grant", 32'(grant), 32'(eg));
    chk("busy",  32'(busy),  32'(eg != '0));
    chk("leds",  32'(leds),  32'(m_leds));
  endtask

  initial begin
    // Reset for two cycles with no requests.
    reset = 1'b1; req = '0;
    tick(); tick();
    chk("rst_leds", 32'(leds), 32'h00);
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) tick();

    // Single uncontended owner with live pattern tracking.
    pattern[15:8] = 8'hA5; req = 4'b0010;
    tick();
    chk("single_grant", 32'(grant), 32'h2);
    chk("single_leds", 32'(leds), 32'hA5);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("single_hold", 32'(grant), 32'h2);
    end
    pattern[15:8] = 8'h3C;
    tick();
    chk("single_track", 32'(leds), 32'h3C);
    req = '0;
    tick();

    // Full contention from reset: strict rotation, 4 cycles each, no gaps.
    reset = 1'b1; tick(); reset = 1'b0;
    pattern = 32'h44332211; req = 4'b1111;
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("rr_grant", 32'(grant), 32'(1 << ((k / HC) % N)));
      chk("rr_leds", 32'(leds), 32'(8'h11 * (((k / HC) % N) + 1)));
    end

    // Early release by owner 0 with requester 2 waiting.
    reset = 1'b1; req = '0; tick(); reset = 1'b0;
    req = 4'b0101;
    tick();
    chk("er_first", 32'(grant), 32'h1);
    req = 4'b0100;
    tick();
    chk("er_gap", 32'(grant), 32'h0);
    chk("er_hb", 32'(leds), 32'(m_leds));
    tick();
    chk("er_next", 32'(grant), 32'h4);

    // Reset mid-tenure with owner 2 and ptr 3 must clear ptr.
    tick();
    reset = 1'b1; tick(); reset = 1'b0;
    req = 4'b1010;
    tick();
    chk("mid_rst_ptr", 32'(grant), 32'h2);

    // Withdrawal: requester 1 leaves before expiry, owner 0 renews.
    reset = 1'b1; req = '0; tick(); reset = 1'b0;
    req = 4'b0011;
    tick();
    chk("wd_first", 32'(grant), 32'h1);
    req = 4'b0001;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("wd_hold", 32'(grant), 32'h1);
    end

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) req = N'($urandom_range(0, 15));
      pattern[8*$urandom_range(0, N-1) +: 8] = 8'($urandom);
      reset = ($urandom_range(0, 63) == 0);
      tick();
    end
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
